stereo_window_scheduler: RTL and testbench

//  Sequences the left and right FIFO-to-line-buffer readers of the stereo matcher in lockstep.

---
 rtl/stereo_window_scheduler.sv | 174 +++++++++++++++++
 tb/tb_stereo_window_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_window_scheduler.sv
// stereo_window_scheduler
//   Drives the left and right FIFO-to-line-buffer readers of the stereo matcher
//   with one shared read request, so both sides always stream the same pixel.
//   Streaming starts once both 3-row line buffers are primed. A request is issued
//   only while both FIFOs hold data and the matcher can take a pixel. The block
//   also tracks the column and row of the returning data and flags window
//   validity, line end, frame end and left/right priming skew.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   i_frame_start     arms a new frame (accepted in IDLE/DONE only)
//   i_abort           synchronous return to IDLE
//   i_left_primed     left line buffer holds 3 rows
//   i_right_primed    right line buffer holds 3 rows
//   i_left_empty      left FIFO empty
//   i_right_empty     right FIFO empty
//   i_match_ready     matcher accepts a window next cycle
//   o_read_request    shared read request to both readers
//   o_col, o_row      position of the pixel arriving with o_win_valid
//   o_win_valid       3x3 window complete on both sides
//   o_line_end        last pixel of a line
//   o_frame_end       last pixel of the frame
//   o_busy            high in PRIME/RUN/GAP
//   o_skew_err        sticky priming skew error
//
// state | meaning
// IDLE  | waiting for i_frame_start
// PRIME | waiting for both line buffers to be primed, skew timer active
// RUN   | streaming one line, one request per accepted pixel
// GAP   | single bubble cycle between lines
// DONE  | last line issued, back to IDLE (or PRIME on a new start)

module stereo_window_scheduler #(
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int SKEW_MAX = 1023,
  parameter int CW       = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_frame_start,
  input  logic          i_abort,
  input  logic          i_left_primed,
  input  logic          i_right_primed,
  input  logic          i_left_empty,
  input  logic          i_right_empty,
  input  logic          i_match_ready,
  output logic          o_read_request,
  output logic [CW-1:0] o_col,
  output logic [CW-1:0] o_row,
  output logic          o_win_valid,
  output logic          o_line_end,
  output logic          o_frame_end,
  output logic          o_busy,
  output logic          o_skew_err
);

  localparam int SW = (SKEW_MAX > 0) ? $clog2(SKEW_MAX + 1) : 1;
  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_LINE = CW'(IMG_H - 4);
  localparam logic [SW-1:0] SKEW_LOAD = SW'(SKEW_MAX);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    RUN   = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic [SW-1:0] skew_cnt;
  logic          req_next;
  logic          fifo_ok;
  logic          last_col;
  logic          last_line;
  logic          start_ok;

  assign fifo_ok   = i_match_ready && !i_left_empty && !i_right_empty;
  // col/row always describe the request currently on o_read_request
  assign last_col  = o_read_request && (col == LAST_COL);
  assign last_line = (row == LAST_LINE);
  assign start_ok  = ((state == IDLE) || (state == DONE)) && i_frame_start && !i_abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_frame_start) state_next = PRIME;
      PRIME:   if (i_left_primed && i_right_primed) state_next = RUN;
      RUN:     if (last_col) state_next = last_line ? DONE : GAP;
      GAP:     state_next = RUN;
      DONE:    state_next = i_frame_start ? PRIME : IDLE;
      default: state_next = IDLE;
    endcase
    if (i_abort) state_next = IDLE;
  end

  // Request is registered but decided on the next state, so it is only ever
  // visible while the FSM sits in RUN (first request lands on the RUN entry cycle).
  always_comb begin
    req_next = (state_next == RUN) && fifo_ok;
    o_busy   = (state == PRIME) || (state == RUN) || (state == GAP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if ((state_next != RUN) && (state_next != GAP)) begin
      col <= '0;
      row <= '0;
    end else if (o_read_request) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Data returns one cycle after the request; position flags follow it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_read_request <= 1'b0;
      o_win_valid    <= 1'b0;
      o_line_end     <= 1'b0;
      o_frame_end    <= 1'b0;
      o_col          <= '0;
      o_row          <= '0;
    end else begin
      o_read_request <= req_next;
      if (i_abort) begin
        o_win_valid <= 1'b0;
        o_line_end  <= 1'b0;
        o_frame_end <= 1'b0;
        o_col       <= '0;
        o_row       <= '0;
      end else begin
        o_win_valid <= o_read_request && (col >= CW'(2));
        o_line_end  <= last_col;
        o_frame_end <= last_col && last_line;
        if (o_read_request) begin
          o_col <= col;
          o_row <= row;
        end
      end
    end
  end

  // Skew timer counts down over one-sided primed cycles; a skewed cycle seen
  // with the timer already at zero is the (SKEW_MAX+1)th and raises the error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skew_cnt   <= '0;
      o_skew_err <= 1'b0;
    end else if (start_ok) begin
      skew_cnt   <= SKEW_LOAD;
      o_skew_err <= 1'b0;
    end else if ((state == PRIME) && (i_left_primed ^ i_right_primed)) begin
      if (skew_cnt == '0) o_skew_err <= 1'b1;
      else                skew_cnt   <= skew_cnt - SW'(1);
    end
  end

endmodule

// File: tb/tb_stereo_window_scheduler.sv
// Directed bench for stereo_window_scheduler on an 8x6 image.
// Instance a uses the default skew limit, instance b uses a limit of 3.

module tb_stereo_window_scheduler;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CW = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_start = 1'b0;
  logic abort = 1'b0;
  logic left_primed = 1'b0;
  logic right_primed = 1'b0;
  logic left_empty = 1'b0;
  logic right_empty = 1'b0;
  logic match_ready = 1'b1;

  logic          a_req, a_win, a_le, a_fe, a_busy, a_err;
  logic [CW-1:0] a_col, a_row;
  logic          b_req, b_win, b_le, b_fe, b_busy, b_err;
  logic [CW-1:0] b_col, b_row;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stereo_window_scheduler #(.IMG_W(W), .IMG_H(H), .SKEW_MAX(1023), .CW(CW)) dut_a (
    .clk(clk), .rst(rst), .i_frame_start(frame_start), .i_abort(abort),
    .i_left_primed(left_primed), .i_right_primed(right_primed),
    .i_left_empty(left_empty), .i_right_empty(right_empty), .i_match_ready(match_ready),
    .o_read_request(a_req), .o_col(a_col), .o_row(a_row), .o_win_valid(a_win),
    .o_line_end(a_le), .o_frame_end(a_fe), .o_busy(a_busy), .o_skew_err(a_err)
  );

  stereo_window_scheduler #(.IMG_W(W), .IMG_H(H), .SKEW_MAX(3), .CW(CW)) dut_b (
    .clk(clk), .rst(rst), .i_frame_start(frame_start), .i_abort(abort),
    .i_left_primed(left_primed), .i_right_primed(right_primed),
    .i_left_empty(left_empty), .i_right_empty(right_empty), .i_match_ready(match_ready),
    .o_read_request(b_req), .o_col(b_col), .o_row(b_row), .o_win_valid(b_win),
    .o_line_end(b_le), .o_frame_end(b_fe), .o_busy(b_busy), .o_skew_err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one full frame from IDLE with both buffers primed. Optional right-FIFO
  // stall window and alternating matcher ready.
  task automatic run_frame(input string tag, input int stall_at, input int stall_len,
                           input bit toggle, input bit check_gaps);
    int exp_row, exp_col, n_req, n_le, n_win, data_cnt, zero_run, n_gaps, bad_gap;
    bit prev_req, seen_req, done, ok_applied;
    exp_row = 0; exp_col = 2; n_req = 0; n_le = 0; n_win = 0; data_cnt = 0;
    zero_run = 0; n_gaps = 0; bad_gap = 0;
    prev_req = 1'b0; seen_req = 1'b0; done = 1'b0;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    chk({tag, "_busy_prime"}, a_busy, 1);
    for (int c = 0; c < 300 && !done; c++) begin
      right_empty = (c >= stall_at) && (c < stall_at + stall_len);
      match_ready = toggle ? (c % 2 == 0) : 1'b1;
      ok_applied  = match_ready && !right_empty && !left_empty;
      tick;
      if (prev_req) data_cnt++;
      chk({tag, "_req_gate"}, a_req && !ok_applied, 0);
      if (a_req) begin
        n_req++;
        if (seen_req && zero_run > 0) begin
          n_gaps++;
          if (zero_run != 1) bad_gap++;
        end
        seen_req = 1'b1;
        zero_run = 0;
      end else if (seen_req) begin
        zero_run++;
      end
      if (a_win) begin
        n_win++;
        chk({tag, "_win_col"}, a_col, exp_col);
        chk({tag, "_win_row"}, a_row, exp_row);
        exp_col++;
        if (exp_col == W) begin
          exp_col = 2;
          exp_row++;
        end
      end
      if (a_le) n_le++;
      if (a_fe) begin
        chk({tag, "_fe_with_le"}, a_le, 1);
        chk({tag, "_fe_data_cycle"}, data_cnt, 24);
        chk({tag, "_fe_col"}, a_col, W - 1);
        chk({tag, "_fe_row"}, a_row, H - 4);
        chk({tag, "_busy_done"}, a_busy, 0);
        done = 1'b1;
      end
      prev_req = a_req;
    end
    chk({tag, "_frame_end_seen"}, done, 1);
    chk({tag, "_n_req"}, n_req, 24);
    chk({tag, "_n_line_end"}, n_le, 3);
    chk({tag, "_n_win"}, n_win, 18);
    chk({tag, "_rows_done"}, exp_row, 3);
    if (check_gaps) begin
      chk({tag, "_n_gaps"}, n_gaps, 2);
      chk({tag, "_gap_len_bad"}, bad_gap, 0);
    end
    right_empty = 1'b0;
    match_ready = 1'b1;
    tick;
    chk({tag, "_idle_busy"}, a_busy, 0);
    chk({tag, "_idle_req"}, a_req, 0);
  endtask

  initial begin
    int n;
    bit found;

    // reset state
    tick;
    tick;
    chk("rst_req", a_req, 0);
    chk("rst_win", a_win, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_err", b_err, 0);
    rst = 1'b1;
    tick;
    chk("post_rst_busy", a_busy, 0);
    chk("post_rst_col", a_col, 0);

    // T3: left primed 5 cycles before right
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    chk("t3_busy", a_busy, 1);
    left_primed = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick;
      chk("t3_no_req", a_req, 0);
      if (i == 3) chk("t3_b_err_at_limit", b_err, 0);
      if (i == 4) chk("t3_b_err_over", b_err, 1);
    end
    right_primed = 1'b1;
    tick;
    chk("t3_first_req", a_req, 1);
    chk("t3_a_err", a_err, 0);
    chk("t3_b_err", b_err, 1);
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    chk("t3_start_ignored_err", b_err, 1);
    chk("t3_start_ignored_busy", a_busy, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("t3_abort_req", a_req, 0);
    chk("t3_abort_busy", a_busy, 0);
    chk("t3_abort_err_holds", b_err, 1);

    // T2: clean frame
    run_frame("t2", 1000, 0, 1'b0, 1'b1);
    chk("t2_b_err_cleared", b_err, 0);

    // T4: right FIFO empty 4 cycles where col 5 would be requested
    run_frame("t4", 5, 4, 1'b0, 1'b0);

    // T5: matcher ready alternating
    run_frame("t5", 1000, 0, 1'b1, 1'b0);

    // T6: abort at row 1 col 3
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick;
      if (a_req) n++;
      if (n == 12) found = 1'b1;
    end
    chk("t6_reached", found, 1);
    chk("t6_pre_col", a_col, 2);
    chk("t6_pre_row", a_row, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("t6_abort_req", a_req, 0);
    chk("t6_abort_win", a_win, 0);
    chk("t6_abort_busy", a_busy, 0);
    tick;
    chk("t6_idle_req", a_req, 0);
    abort = 1'b1;
    frame_start = 1'b1;
    tick;
    abort = 1'b0;
    frame_start = 1'b0;
    chk("t6_abort_wins_busy", a_busy, 0);
    tick;
    chk("t6_abort_wins_req", a_req, 0);
    run_frame("t6_restart", 1000, 0, 1'b0, 1'b0);

    // T1: reset mid-RUN
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    for (int i = 0; i < 6; i++) tick;
    chk("t1_pre_win", a_win, 1);
    chk("t1_pre_req", a_req, 1);
    rst = 1'b0;
    #1;
    chk("t1_rst_req", a_req, 0);
    chk("t1_rst_win", a_win, 0);
    chk("t1_rst_col", a_col, 0);
    chk("t1_rst_busy", a_busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t1_stay_idle_req", a_req, 0);
    end
    chk("t1_stay_idle_busy", a_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
